// File: rtl/mips_pkg.sv
// Shared definitions for the memory port arbiter slice.
// Holds the arbiter state encoding, wait-counter width and default timeout.
package mips_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE       = 2'd0,
        ARB_DATA_WAIT  = 2'd1,
        ARB_FETCH_WAIT = 2'd2
    } arb_state_e;

    localparam int unsigned ARB_TIMEOUT_DEF = 15;
    localparam int unsigned ARB_CNT_W       = 8;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Wait-cycle counter for the arbiter: cleared on issue, counts wait cycles.
// Ports: clk, reset, clr (restart), en (count), tc (last wait cycle reached).
module arb_timeout_ctr
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [ARB_CNT_W-1:0] LAST = ARB_CNT_W'(TIMEOUT - 1);

    logic [ARB_CNT_W-1:0] cnt_q;
    logic [ARB_CNT_W-1:0] cnt_d;

    // tc marks the TIMEOUT-th wait cycle; counter parks there.
    assign tc = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !tc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared RAM port between IF fetches and MEM loads/stores.
// Ports: IF/MEM requests in, registered RAM strobe out, results, stalls, bus_err.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              memreadMEM,
    input  logic              memwriteMEM,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [DATA_W-1:0] instr_out,
    output logic [DATA_W-1:0] load_data,
    output logic              PCWrite,
    output logic              IFIDWrite,
    output logic              pipe_stall,
    output logic              bus_err
);

    arb_state_e        state_q, state_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] load_q, load_d;
    logic              bus_err_q, bus_err_d;
    logic              is_load_q, is_load_d;
    logic              done_q, done_d;

    logic              data_req;
    logic              fetch_done;
    logic              ctr_clr;
    logic              ctr_tc;

    // The MEM instruction just served is still present for one cycle
    // while the pipe advances; done_q keeps it from being reissued.
    assign data_req   = (memreadMEM | memwriteMEM) & ~done_q;
    assign fetch_done = (state_q == ARB_FETCH_WAIT) & ram_ack;

    arb_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_ctr (
        .clk  (clk),
        .reset(reset),
        .clr  (ctr_clr),
        .en   (state_q != ARB_IDLE),
        .tc   (ctr_tc)
    );

    always_comb begin
        state_d     = state_q;
        ram_en_d    = ram_en_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        instr_d     = instr_q;
        load_d      = load_q;
        bus_err_d   = bus_err_q;
        is_load_d   = is_load_q;
        done_d      = 1'b0;
        ctr_clr     = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (data_req) begin
                    state_d     = ARB_DATA_WAIT;
                    ram_en_d    = 1'b1;
                    ram_we_d    = memwriteMEM;
                    ram_addr_d  = mem_addr;
                    ram_wdata_d = mem_wdata;
                    is_load_d   = memreadMEM & ~memwriteMEM;
                    ctr_clr     = 1'b1;
                end else if (if_req) begin
                    state_d    = ARB_FETCH_WAIT;
                    ram_en_d   = 1'b1;
                    ram_we_d   = 1'b0;
                    ram_addr_d = if_addr;
                    ctr_clr    = 1'b1;
                end
            end
            ARB_DATA_WAIT: begin
                if (ram_ack) begin
                    if (is_load_q) begin
                        load_d = ram_rdata;
                    end
                    state_d  = ARB_IDLE;
                    ram_en_d = 1'b0;
                    ram_we_d = 1'b0;
                    done_d   = 1'b1;
                end else if (ctr_tc) begin
                    state_d   = ARB_IDLE;
                    ram_en_d  = 1'b0;
                    ram_we_d  = 1'b0;
                    bus_err_d = 1'b1;
                    done_d    = 1'b1;
                end
            end
            ARB_FETCH_WAIT: begin
                if (ram_ack) begin
                    instr_d  = ram_rdata;
                    state_d  = ARB_IDLE;
                    ram_en_d = 1'b0;
                end else if (ctr_tc) begin
                    state_d   = ARB_IDLE;
                    ram_en_d  = 1'b0;
                    bus_err_d = 1'b1;
                end
            end
            default: begin
                state_d  = ARB_IDLE;
                ram_en_d = 1'b0;
                ram_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            instr_q     <= '0;
            load_q      <= '0;
            bus_err_q   <= 1'b0;
            is_load_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            instr_q     <= instr_d;
            load_q      <= load_d;
            bus_err_q   <= bus_err_d;
            is_load_q   <= is_load_d;
            done_q      <= done_d;
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign instr_out = instr_q;
    assign load_data = load_q;
    assign bus_err   = bus_err_q;

    assign pipe_stall = ~reset &
        (((state_q == ARB_IDLE) & data_req) |
         (state_q == ARB_DATA_WAIT));
    assign PCWrite    = reset | ~if_req | fetch_done;
    assign IFIDWrite  = reset | ~if_req | fetch_done;

endmodule
